clock_monitor: RTL and testbench
================================

# clock_monitor

Frequency checker for divided clocks. Samples a slow clock (typically `clock_signal` from the clock divider) in the `clk_FPGA` domain and measures each period in reference cycles. Compares each period against the expected ratio and reports lock, per-period faults and loss of clock. Sits beside every divider instance as the receiving end of the divided clock, and feeds the status logic.

## Interface
- `REFERENCE_CLOCK`, 50_000_000, reference clock frequency in Hz.
- `FREQUENCY`, 12_500_000, expected frequency of the monitored clock in Hz.
- `EXPECTED_PERIOD`, REFERENCE_CLOCK/FREQUENCY (4), nominal period in reference cycles.
- `TOLERANCE`, 1, maximum accepted |period − EXPECTED_PERIOD|.
- `LOCK_COUNT`, 4, number of consecutive good periods needed to assert `locked`.
- `TIMEOUT_CYCLES`, 4*EXPECTED_PERIOD (16), number of cycles without an edge before a timeout.
- `NBITS_FOR_COUNTER`, CeilLog2(TIMEOUT_CYCLES) (5), width of the period counter.
- `clk_FPGA`, in, 1, reference clock. The whole block uses this one clock.
- `reset`, in, 1, synchronous reset, active-high.
- `enable`, in, 1, measurement enable.
- `clock_signal`, in, 1, monitored clock. Asynchronous to `clk_FPGA`.
- `period`, out, NBITS_FOR_COUNTER, last measured period in cycles.
- `period_valid`, out, 1, one-cycle pulse when `period` updates.
- `locked`, out, 1, level output: frequency is within tolerance.
- `fault`, out, 1, one-cycle pulse on an out-of-tolerance period.
- `timeout`, out, 1, one-cycle pulse on loss of clock.

## Operation
- `clock_signal` passes through a 2-FF synchronizer and a third delay flop. Rising edge = sync2 & !sync3. The synchronizer runs regardless of `enable`.
- FSM states:
  - IDLE: counter 0, `locked`=0. Go to WAIT_EDGE when `enable`=1.
  - WAIT_EDGE: counter counts. On the first edge: counter←0, go to MEASURE, no `period_valid`. If counter reaches TIMEOUT_CYCLES−1: pulse `timeout`, stay in WAIT_EDGE, counter←0.
  - MEASURE: counter increments on each cycle without an edge. On an edge:
    - `period`←counter+1 and `period_valid`=1.
    - Counter←0.
    - Good period (within tolerance): good-count increments, saturating at LOCK_COUNT; `locked`=1 once it reaches LOCK_COUNT.
    - Bad period: `fault`=1, good-count←0, `locked`←0.
  - MEASURE timeout: counter reaches TIMEOUT_CYCLES−1 with no edge. Pulse `timeout`, `locked`←0, good-count←0, go to WAIT_EDGE. No `period_valid`.
- `enable`=0 in any state: next state is IDLE. Counter, good-count and `locked` clear. `period` holds its last value.
- Edge and timeout in the same cycle: the edge wins and no timeout is raised.
- Counter arithmetic is unsigned. It never exceeds TIMEOUT_CYCLES−1, so it cannot wrap. The tolerance check uses an absolute difference computed one bit wider than NBITS_FOR_COUNTER.

## Timing
- Reset values: `period`=0, `period_valid`=0, `locked`=0, `fault`=0, `timeout`=0. FSM in IDLE, synchronizer flops at 0.
- Latency: a rising edge on `clock_signal` sampled at clock n gives `period_valid`/`fault` registered at n+3.
- `locked` rises in the same cycle as the `period_valid` of the LOCK_COUNT-th consecutive good period.
- `locked` falls in the same cycle as the `fault`/`timeout` pulse.
- Reset mid-MEASURE: all outputs return to their reset values on the next edge of `clk_FPGA`.
- All outputs are registered.

## Structure
- `clock_monitor_pkg`:
  - FSM enum `state_t` {IDLE, WAIT_EDGE, MEASURE}.
  - Functions `CeilLog2` and `MaxValue` shared with the divider.
- Sub-module `sync_edge_detector`: 2-FF synchronizer plus rising-edge pulse, with a parameterized number of stages (default 2).

## Test plan
- Divider at 12.5 MHz with enable=1 → `period_valid` every 4 cycles with `period`=4. `locked`=1 on the 4th valid period. No `fault`.
- Monitored clock at 8.33 MHz (period 6) → `period`=6 with `fault` on every edge. `locked` stays 0.
- Period 5 → accepted and `locked` rises. Then period 6 → `fault`, `locked` falls in the same cycle.
- Stop `clock_signal` while locked → `timeout` 16 cycles after the last counted edge, `locked`=0, FSM in WAIT_EDGE. Restart clock → first edge gives no `period_valid`.
- `enable`=0 mid-MEASURE → IDLE next cycle, `locked`=0, `period` held.
- `reset`=1 while locked → all outputs 0 on the next edge. Release → relock after 1+4 edges.

Source files
------------

// File: rtl/clock_monitor_pkg.sv
// Shared types and constant helpers for the clock monitor
// and the clock divider.
package clock_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_EDGE,
    MEASURE
  } state_t;

  // Bits needed to hold the value itself (16 -> 5).
  function automatic int CeilLog2(input int value);
    int bits;
    bits = 0;
    for (int v = value; v > 0; v = v >> 1) begin
      bits++;
    end
    return (bits < 1) ? 1 : bits;
  endfunction

  function automatic int MaxValue(input int nbits);
    return (1 << nbits) - 1;
  endfunction

endpackage

// File: rtl/sync_edge_detector.sv
// Multi-flop synchronizer for an asynchronous level with a
// registered single-cycle rising-edge pulse.
module sync_edge_detector #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic signal,
  output logic rise
);

  logic [STAGES-1:0] sync;
  logic              last;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      last <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], signal};
      last <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~last;
    end
  end

endmodule

// File: rtl/clock_monitor.sv
// Measures the period of a slow asynchronous clock in reference
// cycles and reports lock, out-of-tolerance periods and clock loss.
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int REFERENCE_CLOCK   = 50_000_000,
  parameter int FREQUENCY         = 12_500_000,
  parameter int EXPECTED_PERIOD   = REFERENCE_CLOCK / FREQUENCY,
  parameter int TOLERANCE         = 1,
  parameter int LOCK_COUNT        = 4,
  parameter int TIMEOUT_CYCLES    = 4 * EXPECTED_PERIOD,
  parameter int NBITS_FOR_COUNTER = CeilLog2(TIMEOUT_CYCLES)
) (
  input  logic                         clk_FPGA,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         clock_signal,
  output logic [NBITS_FOR_COUNTER-1:0] period,
  output logic                         period_valid,
  output logic                         locked,
  output logic                         fault,
  output logic                         timeout
);

  localparam int NB = NBITS_FOR_COUNTER;
  localparam int GW = CeilLog2(LOCK_COUNT);

  localparam logic [NB-1:0] CNT_LAST = NB'(TIMEOUT_CYCLES - 1);
  localparam logic [NB-1:0] CNT_ONE  = NB'(1);
  localparam logic [NB:0]   EXP_W    = (NB+1)'(EXPECTED_PERIOD);
  localparam logic [NB:0]   TOL_W    = (NB+1)'(TOLERANCE);
  localparam logic [NB:0]   ONE_W    = (NB+1)'(1);
  localparam logic [GW-1:0] LOCK_N   = GW'(LOCK_COUNT);
  localparam logic [GW-1:0] GOOD_ONE = GW'(1);

  state_t        state;
  logic [NB-1:0] counter;
  logic [GW-1:0] good_cnt;
  logic          rise;
  logic [NB:0]   meas;
  logic [NB:0]   diff;
  logic          good;

  sync_edge_detector #(
    .STAGES(2)
  ) u_sync (
    .clk   (clk_FPGA),
    .reset (reset),
    .signal(clock_signal),
    .rise  (rise)
  );

  // One bit wider so the difference never wraps.
  always_comb begin
    meas = {1'b0, counter} + ONE_W;
    diff = (meas >= EXP_W) ? (meas - EXP_W)
                           : (EXP_W - meas);
    good = (diff <= TOL_W);
  end

  always_ff @(posedge clk_FPGA) begin
    if (reset) begin
      state        <= IDLE;
      counter      <= '0;
      good_cnt     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      fault        <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      fault        <= 1'b0;
      timeout      <= 1'b0;
      if (!enable) begin
        state    <= IDLE;
        counter  <= '0;
        good_cnt <= '0;
        locked   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            counter <= '0;
            locked  <= 1'b0;
            state   <= WAIT_EDGE;
          end
          WAIT_EDGE: begin
            if (rise) begin
              counter <= '0;
              state   <= MEASURE;
            end else if (counter == CNT_LAST) begin
              timeout <= 1'b1;
              counter <= '0;
            end else begin
              counter <= counter + CNT_ONE;
            end
          end
          MEASURE: begin
            // An edge on the last count wins over the timeout.
            if (rise) begin
              period       <= meas[NB-1:0];
              period_valid <= 1'b1;
              counter      <= '0;
              if (good) begin
                if (good_cnt != LOCK_N) begin
                  good_cnt <= good_cnt + GOOD_ONE;
                end
                locked <= (good_cnt >= LOCK_N - GOOD_ONE);
              end else begin
                fault    <= 1'b1;
                good_cnt <= '0;
                locked   <= 1'b0;
              end
            end else if (counter == CNT_LAST) begin
              timeout  <= 1'b1;
              locked   <= 1'b0;
              good_cnt <= '0;
              counter  <= '0;
              state    <= WAIT_EDGE;
            end else begin
              counter <= counter + CNT_ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_monitor.sv
// Self-checking bench for clock_monitor: directed scenarios plus
// random clock patterns against a timestamp-based reference model.
module tb_clock_monitor;

  logic       clk_FPGA = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       clock_signal = 1'b0;
  logic [4:0] period;
  logic       period_valid;
  logic       locked;
  logic       fault;
  logic       timeout;

  always #5 clk_FPGA = ~clk_FPGA;

  clock_monitor dut (
    .clk_FPGA    (clk_FPGA),
    .reset       (reset),
    .enable      (enable),
    .clock_signal(clock_signal),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .fault       (fault),
    .timeout     (timeout)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: cycle stamps of samples and of the last event.
  bit samp [0:19999];
  int k = 0;
  int rst_k = -1;
  int mode = 0;
  int tref = 0;
  int streak = 0;
  int m_period = 0;
  bit m_pv = 0;
  bit m_f = 0;
  bit m_to = 0;
  bit m_lock = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d",
             tag, obs, exp, k);
    end
  endtask

  function automatic bit get(input int j);
    return (j > rst_k && j >= 0) ? samp[j] : 1'b0;
  endfunction

  task automatic model_step();
    bit e;
    int el;
    int dev;
    k++;
    samp[k] = reset ? 1'b0 : clock_signal;
    if (reset) rst_k = k;
    // A sampled rising edge is acted on three cycles later.
    e = get(k - 3) && !get(k - 4);
    m_pv = 0;
    m_f = 0;
    m_to = 0;
    if (reset) begin
      mode = 0;
      m_lock = 0;
      streak = 0;
      m_period = 0;
    end else if (!enable) begin
      mode = 0;
      m_lock = 0;
      streak = 0;
    end else if (mode == 0) begin
      mode = 1;
      tref = k;
    end else if (mode == 1) begin
      if (e) begin
        mode = 2;
        tref = k;
      end else if (k - tref == 16) begin
        m_to = 1;
        tref = k;
      end
    end else begin
      el = k - tref;
      if (e) begin
        m_period = el;
        m_pv = 1;
        tref = k;
        dev = (el >= 4) ? el - 4 : 4 - el;
        if (dev <= 1) begin
          streak = (streak < 4) ? streak + 1 : 4;
          m_lock = (streak == 4);
        end else begin
          m_f = 1;
          streak = 0;
          m_lock = 0;
        end
      end else if (el == 16) begin
        m_to = 1;
        m_lock = 0;
        streak = 0;
        mode = 1;
        tref = k;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_FPGA);
    model_step();
    #1;
    chk("period", period, m_period);
    chk("period_valid", period_valid, m_pv);
    chk("locked", locked, m_lock);
    chk("fault", fault, m_f);
    chk("timeout", timeout, m_to);
  endtask

  task automatic run_clk(input int p, input int n);
    int hi;
    hi = p / 2;
    repeat (n) begin
      clock_signal = 1'b1;
      repeat (hi) tick();
      clock_signal = 1'b0;
      repeat (p - hi) tick();
    end
  endtask

  initial begin
    int r;
    reset = 1'b1;
    enable = 1'b0;
    clock_signal = 1'b0;
    tick();
    tick();
    chk("rst_period", period, 0);
    chk("rst_locked", locked, 0);
    chk("rst_pv", period_valid, 0);
    reset = 1'b0;
    enable = 1'b1;

    run_clk(4, 8);
    chk("p4_locked", locked, 1);
    chk("p4_period", period, 4);

    run_clk(6, 5);
    chk("p6_locked", locked, 0);
    chk("p6_period", period, 6);

    run_clk(5, 8);
    chk("p5_locked", locked, 1);
    chk("p5_period", period, 5);
    run_clk(6, 2);
    chk("p5to6_locked", locked, 0);

    run_clk(4, 6);
    chk("relock", locked, 1);
    clock_signal = 1'b0;
    repeat (24) tick();
    chk("stop_locked", locked, 0);
    run_clk(4, 3);

    run_clk(4, 6);
    enable = 1'b0;
    repeat (3) tick();
    chk("dis_locked", locked, 0);
    chk("dis_period", period, 4);
    enable = 1'b1;

    run_clk(4, 6);
    chk("pre_rst_locked", locked, 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_period", period, 0);
    chk("mid_rst_locked", locked, 0);
    reset = 1'b0;
    run_clk(4, 8);
    chk("post_rst_locked", locked, 1);

    run_clk(16, 2);
    chk("p16_period", period, 16);
    run_clk(17, 2);
    chk("p17_locked", locked, 0);

    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end else if (r < 3) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 6)) tick();
        enable = 1'b1;
      end else if (r < 6) begin
        clock_signal = 1'b0;
        repeat ($urandom_range(8, 40)) tick();
      end else begin
        run_clk(int'($urandom_range(2, 8)),
                int'($urandom_range(1, 8)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
